// File: rtl/trig_pkg.sv
// +----------------------------------------------------------------------+
// | trig_pkg: shared types, constants and cosine table for trig_bcd_unit |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

package trig_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REDUCE  = 3'd1,
    S_FOLD    = 3'd2,
    S_LOOKUP  = 3'd3,
    S_CONVERT = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  localparam logic MODE_COS = 1'b0;
  localparam logic MODE_SIN = 1'b1;

  // round(cos(i deg) * 10000), i = 0..90
  localparam logic [13:0] COS_LUT [0:90] = '{
    14'd10000, 14'd9998, 14'd9994, 14'd9986, 14'd9976, 14'd9962, 14'd9945, 14'd9925, 14'd9903, 14'd9877,
    14'd9848,  14'd9816, 14'd9781, 14'd9744, 14'd9703, 14'd9659, 14'd9613, 14'd9563, 14'd9511, 14'd9455,
    14'd9397,  14'd9336, 14'd9272, 14'd9205, 14'd9135, 14'd9063, 14'd8988, 14'd8910, 14'd8829, 14'd8746,
    14'd8660,  14'd8572, 14'd8480, 14'd8387, 14'd8290, 14'd8192, 14'd8090, 14'd7986, 14'd7880, 14'd7771,
    14'd7660,  14'd7547, 14'd7431, 14'd7314, 14'd7193, 14'd7071, 14'd6947, 14'd6820, 14'd6691, 14'd6561,
    14'd6428,  14'd6293, 14'd6157, 14'd6018, 14'd5878, 14'd5736, 14'd5592, 14'd5446, 14'd5299, 14'd5150,
    14'd5000,  14'd4848, 14'd4695, 14'd4540, 14'd4384, 14'd4226, 14'd4067, 14'd3907, 14'd3746, 14'd3584,
    14'd3420,  14'd3256, 14'd3090, 14'd2924, 14'd2756, 14'd2588, 14'd2419, 14'd2250, 14'd2079, 14'd1908,
    14'd1736,  14'd1564, 14'd1392, 14'd1219, 14'd1045, 14'd872,  14'd698,  14'd523,  14'd349,  14'd175,
    14'd0
  };

  function automatic int pow10(input int n);
    int r;
    r = 1;
    for (int i = 0; i < n; i++) begin
      r = r * 10;
    end
    return r;
  endfunction

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) begin
      r = r + 1;
    end
    return r;
  endfunction

  function automatic logic [13:0] cos_lut(input logic [6:0] idx);
    if (idx > 7'd90) begin
      return 14'd0;
    end
    return COS_LUT[idx];
  endfunction

endpackage

`default_nettype wire

// File: rtl/trig_bcd_unit_if.sv
// +----------------------------------------------------------------------+
// | trig_bcd_unit_if: start/busy/done request and result bundle          |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

interface trig_bcd_unit_if #(
  parameter int ANGLE_W     = 9,
  parameter int FRAC_DIGITS = 2
);
  localparam int c_bcd_w = 4 * (FRAC_DIGITS + 1);

  logic               start;
  logic               mode;
  logic [ANGLE_W-1:0] angle;
  logic               busy;
  logic               done;
  logic               sign;
  logic [c_bcd_w-1:0] bcd;
  logic               err;

  modport master (
    output start, mode, angle,
    input  busy, done, sign, bcd, err
  );

  modport slave (
    input  start, mode, angle,
    output busy, done, sign, bcd, err
  );
endinterface

`default_nettype wire

// File: rtl/bin2bcd_seq.sv
// +----------------------------------------------------------------------+
// | bin2bcd_seq: serial double-dabble, one bit per cycle, IN_W cycles    |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module bin2bcd_seq #(
  parameter int IN_W   = 7,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [IN_W-1:0]       bin,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);
  localparam int c_cnt_w = $clog2(IN_W + 1);

  logic [IN_W-1:0]     r_bin;
  logic [4*DIGITS-1:0] r_bcd;
  logic [4*DIGITS-1:0] w_adj;
  logic [4*DIGITS-1:0] w_bcd_nxt;
  logic [c_cnt_w-1:0]  r_cnt;

  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) begin
        w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
      end
    end
  end

  assign w_bcd_nxt = {w_adj[4*DIGITS-2:0], r_bin[IN_W-1]};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_bin <= '0;
      r_bcd <= '0;
      r_cnt <= '0;
    end else if (load) begin
      r_bin <= bin;
      r_bcd <= '0;
      r_cnt <= c_cnt_w'(IN_W);
    end else if (r_cnt != '0) begin
      r_bin <= r_bin << 1;
      r_bcd <= w_bcd_nxt;
      r_cnt <= r_cnt - c_cnt_w'(1);
    end
  end

  // Result is presented combinationally during the last shift cycle so the
  // caller can capture it on the same edge that completes the conversion.
  assign done = (r_cnt == c_cnt_w'(1));
  assign bcd  = w_bcd_nxt;

endmodule

`default_nettype wire

// File: rtl/trig_bcd_unit.sv
// +----------------------------------------------------------------------+
// | trig_bcd_unit: sequential sin/cos to sign + BCD magnitude            |
// | Option macro: TRIG_RANGE_CHK_EN (flag angles >= 360 instead of wrap) |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module trig_bcd_unit
  import trig_pkg::*;
#(
  parameter int ANGLE_W     = 9,
  parameter int FRAC_DIGITS = 2
) (
  input  logic            clk,
  input  logic            reset,
  trig_bcd_unit_if.slave  bus
);
  localparam int c_digits = FRAC_DIGITS + 1;
  localparam int c_bcd_w  = 4 * c_digits;
  localparam int c_mag_w  = clog2(pow10(FRAC_DIGITS) + 1);
  localparam int c_a_w    = ANGLE_W + 1;
  localparam int c_div    = pow10(4 - FRAC_DIGITS);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [c_a_w-1:0]   r_a;
  logic [c_a_w-1:0]   w_a_load;
  logic [6:0]         r_idx;
  logic [6:0]         w_fold_idx;
  logic               r_neg;
  logic               w_fold_neg;
  logic               r_sign_cv;
  logic               r_sign;
  logic [c_bcd_w-1:0] r_bcd;
  logic [13:0]        w_lut;
  logic [c_mag_w-1:0] w_mag;
  logic [c_bcd_w-1:0] w_conv_bcd;
  logic               w_accept;
  logic               w_reduce_sub;
  logic               w_conv_load;
  logic               w_conv_done;
  logic               w_finish;
  logic               w_range_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_conv_load = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_REDUCE;
        end
      end
      S_REDUCE: begin
        if (!w_reduce_sub) begin
          w_state_nxt = S_FOLD;
        end
      end
      S_FOLD:   w_state_nxt = S_LOOKUP;
      S_LOOKUP: begin
        w_conv_load = 1'b1;
        w_state_nxt = S_CONVERT;
      end
      S_CONVERT: begin
        if (w_conv_done) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

`ifdef TRIG_RANGE_CHK_EN
  // No reduction loop: the sin offset is applied modulo 360 at load instead.
  always_comb begin
    w_a_load = c_a_w'(bus.angle);
    if (bus.mode == MODE_SIN) begin
      if (bus.angle >= ANGLE_W'(90)) begin
        w_a_load = c_a_w'(bus.angle) - c_a_w'(90);
      end else begin
        w_a_load = c_a_w'(bus.angle) + c_a_w'(270);
      end
    end
  end
  assign w_reduce_sub = 1'b0;
`else
  // sin x = cos(x - 90) = cos(x + 270)
  assign w_a_load     = (bus.mode == MODE_SIN) ? c_a_w'(bus.angle) + c_a_w'(270)
                                               : c_a_w'(bus.angle);
  assign w_reduce_sub = (r_a >= c_a_w'(360));
`endif

  always_comb begin
    w_fold_idx = '0;
    w_fold_neg = 1'b0;
    if (r_a <= c_a_w'(90)) begin
      w_fold_idx = 7'(r_a);
    end else if (r_a <= c_a_w'(180)) begin
      w_fold_idx = 7'(c_a_w'(180) - r_a);
      w_fold_neg = 1'b1;
    end else if (r_a <= c_a_w'(270)) begin
      w_fold_idx = 7'(r_a - c_a_w'(180));
      w_fold_neg = 1'b1;
    end else begin
      w_fold_idx = 7'(c_a_w'(360) - r_a);
    end
  end

  assign w_lut    = cos_lut(r_idx);
  assign w_mag    = c_mag_w'((15'(w_lut) + 15'(c_div / 2)) / 15'(c_div));
  assign w_finish = (r_state == S_CONVERT) && w_conv_done;

  bin2bcd_seq #(
    .IN_W   (c_mag_w),
    .DIGITS (c_digits)
  ) u_bin2bcd (
    .clk   (clk),
    .reset (reset),
    .load  (w_conv_load),
    .bin   (w_mag),
    .done  (w_conv_done),
    .bcd   (w_conv_bcd)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_a       <= '0;
      r_idx     <= '0;
      r_neg     <= 1'b0;
      r_sign_cv <= 1'b0;
      r_sign    <= 1'b0;
      r_bcd     <= '0;
    end else begin
      if (w_accept) begin
        r_a <= w_a_load;
      end else if ((r_state == S_REDUCE) && w_reduce_sub) begin
        r_a <= r_a - c_a_w'(360);
      end
      if (r_state == S_FOLD) begin
        r_idx <= w_fold_idx;
        r_neg <= w_fold_neg;
      end
      // A magnitude that rounds to zero is always reported as +0.
      if (r_state == S_LOOKUP) begin
        r_sign_cv <= r_neg & (w_mag != '0);
      end
      if (w_finish) begin
        if (w_range_err) begin
          r_sign <= 1'b0;
          r_bcd  <= '1;
        end else begin
          r_sign <= r_sign_cv;
          r_bcd  <= w_conv_bcd;
        end
      end
    end
  end

`ifdef TRIG_RANGE_CHK_EN
  logic r_err_pend;
  logic r_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_err_pend <= 1'b0;
      r_err      <= 1'b0;
    end else if (w_accept) begin
      r_err_pend <= (bus.angle >= ANGLE_W'(360));
      r_err      <= 1'b0;
    end else if (w_finish) begin
      r_err <= r_err_pend;
    end
  end

  assign w_range_err = r_err_pend;
  assign bus.err     = r_err;
`else
  assign w_range_err = 1'b0;
  assign bus.err     = 1'b0;
`endif

  assign bus.busy = (r_state != S_IDLE);
  assign bus.done = (r_state == S_DONE);
  assign bus.sign = r_sign;
  assign bus.bcd  = r_bcd;

endmodule

`default_nettype wire

// File: tb/tb_trig_bcd_unit.sv
// +----------------------------------------------------------------------+
// | tb_trig_bcd_unit: scoreboard bench, FRAC_DIGITS = 2 and 4 instances  |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_trig_bcd_unit;
  import trig_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  trig_bcd_unit_if #(.ANGLE_W(9), .FRAC_DIGITS(2)) b2 ();
  trig_bcd_unit_if #(.ANGLE_W(9), .FRAC_DIGITS(4)) b4 ();

  trig_bcd_unit #(.ANGLE_W(9), .FRAC_DIGITS(2)) u_dut2 (.clk(clk), .reset(reset), .bus(b2));
  trig_bcd_unit #(.ANGLE_W(9), .FRAC_DIGITS(4)) u_dut4 (.clk(clk), .reset(reset), .bus(b4));

`ifdef TRIG_RANGE_CHK_EN
  localparam bit c_rchk = 1'b1;
`else
  localparam bit c_rchk = 1'b0;
`endif

  typedef struct {
    logic        sign;
    logic [19:0] bcd;
    logic        err;
    int          lat;
  } exp_t;

  exp_t q2[$];
  exp_t q4[$];
  int   checks = 0;
  int   errors = 0;
  int   lat [2];
  bit   after_done [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Expected result; lat counts busy cycles before done (K + 3 + MAG_W).
  function automatic exp_t mk(input int ang, input logic s, input logic [19:0] bcd,
                              input int k, input int mag_w, input logic [19:0] blank);
    exp_t e;
    if (c_rchk && ang >= 360) begin
      e.sign = 1'b0; e.bcd = blank; e.err = 1'b1; e.lat = 3 + mag_w;
    end else begin
      e.sign = s; e.bcd = bcd; e.err = 1'b0; e.lat = (c_rchk ? 0 : k) + 3 + mag_w;
    end
    return e;
  endfunction

  task automatic mon(input int w, input string tag, input logic done, input logic busy,
                     input logic sign, input logic [19:0] bcd, input logic err);
    exp_t e;
    int   sz;
    if (done === 1'b1) begin
      sz = (w == 0) ? q2.size() : q4.size();
      if (sz == 0) begin
        checks++;
        errors++;
        $display("FAIL %s_unexpected_done: got done=1, expected no pending operation", tag);
      end else begin
        if (w == 0) e = q2.pop_front();
        else        e = q4.pop_front();
        chk({tag, "_sign"}, 32'(sign), 32'(e.sign));
        chk({tag, "_bcd"},  32'(bcd),  32'(e.bcd));
        chk({tag, "_err"},  32'(err),  32'(e.err));
        chk({tag, "_latency"}, 32'(lat[w]), 32'(e.lat));
      end
      lat[w] = 0;
      after_done[w] = 1'b1;
    end else begin
      if (after_done[w]) chk({tag, "_busy_drop"}, 32'(busy), 32'(0));
      after_done[w] = 1'b0;
      lat[w] = (busy === 1'b1) ? lat[w] + 1 : 0;
    end
  endtask

  initial begin
    lat[0] = 0; lat[1] = 0;
    after_done[0] = 1'b0; after_done[1] = 1'b0;
    forever begin
      @(negedge clk);
      mon(0, "d2", b2.done, b2.busy, b2.sign, {8'h00, b2.bcd}, b2.err);
      mon(1, "d4", b4.done, b4.busy, b4.sign, b4.bcd, b4.err);
    end
  end

  task automatic wait_idle2();
    int n = 0;
    while (b2.busy !== 1'b0 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL d2_idle_timeout: got busy=%0b, expected 0 within 100 cycles", b2.busy);
    end
  endtask

  task automatic wait_idle4();
    int n = 0;
    while (b4.busy !== 1'b0 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL d4_idle_timeout: got busy=%0b, expected 0 within 100 cycles", b4.busy);
    end
  endtask

  task automatic issue2(input logic m, input int ang, input logic s, input logic [11:0] bcd,
                        input int k, input bit push);
    wait_idle2();
    b2.mode = m; b2.angle = 9'(ang); b2.start = 1'b1;
    if (push) q2.push_back(mk(ang, s, {8'h00, bcd}, k, 7, 20'h00FFF));
    @(posedge clk); #1;
    b2.start = 1'b0;
  endtask

  task automatic issue4(input logic m, input int ang, input logic s, input logic [19:0] bcd,
                        input int k);
    wait_idle4();
    b4.mode = m; b4.angle = 9'(ang); b4.start = 1'b1;
    q4.push_back(mk(ang, s, bcd, k, 14, 20'hFFFFF));
    @(posedge clk); #1;
    b4.start = 1'b0;
  endtask

  initial begin
    int n;
    b2.start = 1'b0; b2.mode = 1'b0; b2.angle = '0;
    b4.start = 1'b0; b4.mode = 1'b0; b4.angle = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(b2.busy), 0);
    chk("rst_done", 32'(b2.done), 0);
    chk("rst_sign", 32'(b2.sign), 0);
    chk("rst_bcd",  32'(b2.bcd),  0);
    chk("rst_err",  32'(b2.err),  0);
    chk("rst_bcd4", 32'(b4.bcd),  0);
    reset = 1'b0;

    // Quadrant folding, zero-sign suppression, sin offset and reduction
    issue2(MODE_COS, 60,  1'b0, 12'h050, 0, 1);
    issue2(MODE_COS, 120, 1'b1, 12'h050, 0, 1);
    issue2(MODE_COS, 240, 1'b1, 12'h050, 0, 1);
    issue2(MODE_COS, 300, 1'b0, 12'h050, 0, 1);
    issue2(MODE_COS, 90,  1'b0, 12'h000, 0, 1);
    issue2(MODE_COS, 270, 1'b0, 12'h000, 0, 1);
    issue2(MODE_SIN, 90,  1'b0, 12'h100, 1, 1);
    issue2(MODE_SIN, 270, 1'b1, 12'h100, 1, 1);
    issue2(MODE_COS, 400, 1'b0, 12'h077, 1, 1);
    issue2(MODE_COS, 0,   1'b0, 12'h100, 0, 1);
    issue2(MODE_COS, 360, 1'b0, 12'h100, 1, 1);
    issue2(MODE_COS, 511, 1'b1, 12'h087, 1, 1);
    issue2(MODE_SIN, 511, 1'b0, 12'h048, 2, 1);
    issue2(MODE_COS, 45,  1'b0, 12'h071, 0, 1);

    // Starts while busy, including during DONE, must be ignored
    issue2(MODE_COS, 240, 1'b1, 12'h050, 0, 1);
    repeat (3) begin @(posedge clk); #1; end
    b2.mode = MODE_SIN; b2.angle = 9'd45; b2.start = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    b2.start = 1'b0;
    n = 0;
    while (b2.done !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    b2.start = 1'b1;
    @(posedge clk); #1;
    b2.start = 1'b0;

    // Reset during CONVERT aborts without a done pulse
    issue2(MODE_COS, 120, 1'b1, 12'h050, 0, 1);
    issue2(MODE_COS, 60,  1'b0, 12'h050, 0, 0);
    repeat (4) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy", 32'(b2.busy), 0);
    chk("abort_done", 32'(b2.done), 0);
    chk("abort_sign", 32'(b2.sign), 0);
    chk("abort_bcd",  32'(b2.bcd),  0);
    chk("abort_err",  32'(b2.err),  0);
    reset = 1'b0;
    issue2(MODE_COS, 300, 1'b0, 12'h050, 0, 1);

    // Four fractional digits
    issue4(MODE_COS, 45,  1'b0, 20'h07071, 0);
    issue4(MODE_SIN, 30,  1'b0, 20'h05000, 0);
    issue4(MODE_COS, 180, 1'b1, 20'h10000, 0);
    issue4(MODE_SIN, 1,   1'b0, 20'h00175, 0);

    n = 0;
    while ((q2.size() != 0 || q4.size() != 0 || b2.busy !== 1'b0 || b4.busy !== 1'b0) && n < 300) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 300) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d/%0d pending results, expected 0/0", q2.size(), q4.size());
    end
    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
